pll_phase_ctrl: RTL and testbench
=================================

// Module: pll_phase_ctrl
// PURPOSE
//  Sequences dynamic phase-shift steps on the on-chip MAX10 PLL (fiftyfivenm_pll).
//  Accepts one request {counter, direction, step count} per handshake.
//  Drives phasecounterselect/phaseupdown/phasestep and waits on phasedone for every step.
//  Sits between the bus-side tuning register (SDRAM read-clock sweep) and the PLL instance.
// PARAMETERS
//  STEPW      6     width of step-count field; max steps per request = 2**STEPW-1
//  HOLD       2     cycles phasestep is held high per step (>=2)
//  TIMEOUT    255   max cycles waiting on each phasedone edge before error (8-bit counter)
// PORTS
//  i_clk                in   1      sole clock; also drives PLL scanclk
//  i_reset_n            in   1      asynchronous, active-low reset
//  i_req_valid          in   1      request strobe
//  o_req_ready          out  1      high only in IDLE
//  i_req_cnt            in   3      counter select (PLL encoding)
//  i_req_up             in   1      1 = advance phase, 0 = retard
//  i_req_steps          in   STEPW  number of phase steps
//  o_busy               out  1      request in progress
//  o_done               out  1      1-cycle pulse, request completed OK
//  o_err                out  1      sticky; timeout or lock loss; cleared by next accepted request
//  o_steps_left         out  STEPW  remaining steps
//  o_phasecounterselect out  3      to PLL
//  o_phaseupdown        out  1      to PLL
//  o_phasestep          out  1      to PLL
//  i_phasedone          in   1      from PLL, async; low while a step is applied
//  i_locked             in   1      from PLL, async
// BEHAVIOUR
//  Reset: state IDLE; o_req_ready=1; o_busy=0, o_done=0, o_err=0; o_steps_left=0;
//   o_phasecounterselect=0, o_phaseupdown=0, o_phasestep=0; synchronizers cleared.
//  i_phasedone and i_locked pass through 2-FF synchronizers (2-cycle latency) before use.
//  Accept: i_req_valid && o_req_ready. Latch cnt/up/steps. Clear o_err. Go to SETUP.
//   Exception: steps==0 -> no PLL activity; o_done pulses next cycle; stay IDLE.
//  States:
//   IDLE    -> SETUP on accept.
//   SETUP   1 cycle; select/updown driven, phasestep low (setup time).
//   STEP    phasestep=1 for HOLD cycles -> WAIT_LO.
//   WAIT_LO wait for sync phasedone==0 -> WAIT_HI.
//   WAIT_HI wait for sync phasedone==1 -> NEXT.
//   NEXT    decrement steps_left; ==0 -> IDLE with o_done pulse, else -> SETUP.
//  Select/updown are held stable from SETUP through WAIT_HI of every step.
//  Timeout: counter resets on entry to WAIT_LO and to WAIT_HI; hitting TIMEOUT ->
//   o_err=1, phasestep=0, steps_left=0, -> IDLE, no o_done.
//  Lock loss: sync i_locked==0 in any non-IDLE state -> same abort as timeout.
//   Requests are accepted while unlocked; the first SETUP cycle then aborts with error.
//  i_req_valid while busy is ignored (not queued); o_req_ready=0 makes the drop visible.
//  Mid-operation reset: all outputs go to reset values immediately (asynchronous);
//   the PLL finishes any step already started on its own.
//  Minimum per-step latency, ideal PLL: 1 + HOLD + 2-cycle sync per edge.
// STRUCTURE
//  pll_phase_defs.vh: state encodings; counter-select codes
//   (ALL=3'b000, M=3'b001, C0=3'b010, C1=3'b011 ... C4=3'b110).
//  Sub-module sync2ff: 2-FF synchronizer with async active-low reset;
//   instantiated once each for phasedone and locked.
//  Top level contains the FSM, the step counter and the timeout counter only.
// TESTING
//  PLL model: phasedone falls 3 cycles after phasestep rises, rises 4 cycles later.
//  1. Locked; req cnt=C1, up=0, steps=3 -> 3 phasestep pulses, each 2 cycles wide,
//     select=3'b011, updown=0; then one o_done pulse; o_err=0.
//  2. steps=0 -> o_done 1 cycle after accept; o_phasestep never rises.
//  3. Model never lowers phasedone -> o_err=1 exactly 255 cycles into WAIT_LO,
//     o_phasestep=0, back to IDLE; the next request clears o_err.
//  4. Drop i_locked during step 2 of 5 -> abort within 3 cycles; o_err=1;
//     o_steps_left=0; no o_done.
//  5. Hold i_req_valid high through the whole 3-step run -> exactly one request accepted
//     at start; the next is accepted on the cycle IDLE is re-entered.
//  6. Assert i_reset_n=0 mid-WAIT_HI -> all outputs at reset values in the same cycle;
//     after release, o_req_ready=1.

Source files
------------

// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types for the PLL dynamic phase-shift sequencer.
// Holds the FSM state encoding, the PLL counter-select codes and the timeout counter width.
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STEP    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_NEXT    = 3'd5
  } state_e;

  // phasecounterselect encoding of the MAX10 PLL
  localparam logic [2:0] CNT_ALL = 3'b000;
  localparam logic [2:0] CNT_M   = 3'b001;
  localparam logic [2:0] CNT_C0  = 3'b010;
  localparam logic [2:0] CNT_C1  = 3'b011;
  localparam logic [2:0] CNT_C2  = 3'b100;
  localparam logic [2:0] CNT_C3  = 3'b101;
  localparam logic [2:0] CNT_C4  = 3'b110;

  localparam int TMO_W = 8;

endpackage

// File: rtl/pll_phase_ctrl_sync2ff.sv
// Two-flop synchronizer for the asynchronous PLL status lines (phasedone, locked).
// Both stages clear to 0 on reset.
module sync2ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments so the second stage samples the first stage's pre-edge value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences dynamic phase-shift steps on the MAX10 PLL: one request {counter, direction, count}
// per handshake, one phasestep pulse per step, each step closed by a phasedone low/high cycle.
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
#(
  parameter int STEPW   = 6,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_req_cnt,
  input  logic             i_req_up,
  input  logic [STEPW-1:0] i_req_steps,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [STEPW-1:0] o_steps_left,
  output logic [2:0]       o_phasecounterselect,
  output logic             o_phaseupdown,
  output logic             o_phasestep,
  input  logic             i_phasedone,
  input  logic             i_locked
);

  localparam logic [TMO_W-1:0] HOLD_LAST = TMO_W'(HOLD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  logic phasedone_s;
  logic locked_s;

  sync2ff u_sync_done (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_phasedone), .o_q(phasedone_s));
  sync2ff u_sync_lock (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_locked),    .o_q(locked_s));

  state_e            state_q, state_d;
  logic [STEPW-1:0]  steps_left_q, steps_left_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        sel_q, sel_d;
  logic              up_q, up_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              abort;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    tmo_d        = tmo_q;
    sel_d        = sel_q;
    up_d         = up_q;
    err_d        = err_q;
    done_d       = 1'b0;
    abort        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          err_d        = 1'b0;
          sel_d        = i_req_cnt;
          up_d         = i_req_up;
          steps_left_d = i_req_steps;
          if (i_req_steps == '0) done_d  = 1'b1;
          else                   state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STEP;
        tmo_d   = '0;
      end
      // the timeout counter doubles as the phasestep hold counter
      S_STEP: begin
        if (tmo_q == HOLD_LAST) begin
          state_d = S_WAIT_LO;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!phasedone_s) begin
          state_d = S_WAIT_HI;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_HI: begin
        if (phasedone_s) begin
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_NEXT: begin
        steps_left_d = steps_left_q - STEPW'(1);
        if (steps_left_q == STEPW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !locked_s) abort = 1'b1;

    if (abort) begin
      state_d      = S_IDLE;
      err_d        = 1'b1;
      steps_left_d = '0;
      tmo_d        = '0;
      done_d       = 1'b0;
    end

    // outputs are registered from the next state so they change cleanly on the clock
    step_d  = (state_d == S_STEP);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      steps_left_q <= '0;
      tmo_q        <= '0;
      sel_q        <= '0;
      up_q         <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      tmo_q        <= tmo_d;
      sel_q        <= sel_d;
      up_q         <= up_d;
      err_q        <= err_d;
      done_q       <= done_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign o_req_ready          = ready_q;
  assign o_busy               = busy_q;
  assign o_done               = done_q;
  assign o_err                = err_q;
  assign o_steps_left         = steps_left_q;
  assign o_phasecounterselect = sel_q;
  assign o_phaseupdown        = up_q;
  assign o_phasestep          = step_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: directed and random requests against a behavioural
// PLL model; expected per-request outcomes are queued and compared by an independent monitor.
module tb_pll_phase_ctrl;
  import pll_phase_ctrl_pkg::*;

  localparam int STEPW   = 6;
  localparam int HOLD    = 2;
  localparam int TIMEOUT = 255;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_cnt;
  logic             req_up;
  logic [STEPW-1:0] req_steps;
  logic             busy;
  logic             done;
  logic             err;
  logic [STEPW-1:0] steps_left;
  logic [2:0]       pcs;
  logic             updown;
  logic             phasestep;
  logic             phasedone;
  logic             locked;

  pll_phase_ctrl #(.STEPW(STEPW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .i_clk                (clk),
    .i_reset_n            (rst_n),
    .i_req_valid          (req_valid),
    .o_req_ready          (req_ready),
    .i_req_cnt            (req_cnt),
    .i_req_up             (req_up),
    .i_req_steps          (req_steps),
    .o_busy               (busy),
    .o_done               (done),
    .o_err                (err),
    .o_steps_left         (steps_left),
    .o_phasecounterselect (pcs),
    .o_phaseupdown        (updown),
    .o_phasestep          (phasestep),
    .i_phasedone          (phasedone),
    .i_locked             (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected outcome of one request
  typedef struct {
    logic [2:0] sel;
    logic       up;
    int         pulses;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];

  localparam int M_NORMAL = 0;
  localparam int M_STUCK  = 1;
  localparam int M_UNLOCK = 2;

  // Outcome from the request and what the PLL/lock environment will do to it.
  function automatic exp_t model(input logic [2:0] sel, input logic up, input int steps,
                                 input int mode, input int abort_after);
    exp_t e;
    e.sel = sel;
    e.up  = up;
    if (steps == 0) begin
      e.pulses = 0; e.done = 1'b1; e.err = 1'b0;
    end else if (mode == M_NORMAL) begin
      e.pulses = steps; e.done = 1'b1; e.err = 1'b0;
    end else if (mode == M_STUCK) begin
      e.pulses = 1; e.done = 1'b0; e.err = 1'b1;
    end else begin
      e.pulses = (abort_after < steps) ? abort_after : steps;
      e.done = 1'b0; e.err = 1'b1;
    end
    return e;
  endfunction

  // PLL model: phasedone falls 3 cycles after a phasestep rise and returns 4 cycles later.
  logic pll_stuck = 1'b0;
  logic pll_prev  = 1'b0;
  initial begin
    phasedone = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (phasestep && !pll_prev && !pll_stuck) begin
        repeat (3) @(posedge clk);
        #1 phasedone = 1'b0;
        repeat (4) @(posedge clk);
        #1 phasedone = 1'b1;
      end
      pll_prev = phasestep;
    end
  end

  // Monitor: counts pulses per request and closes each request on done or a new error.
  int   mon_pulses = 0;
  int   mon_width  = 0;
  logic mon_ps_prev  = 1'b0;
  logic mon_err_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pulses = 0; mon_width = 0; mon_ps_prev = 1'b0; mon_err_prev = 1'b0;
        continue;
      end
      if (phasestep && !mon_ps_prev) begin
        mon_pulses++;
        mon_width = 1;
        if (sb.size() == 0) check("step_unexpected", 1, 0);
        else begin
          check("select", pcs, sb[0].sel);
          check("updown", updown, sb[0].up);
        end
      end else if (phasestep) begin
        mon_width++;
      end else if (mon_ps_prev) begin
        check("step_width", mon_width, HOLD);
      end
      check("ready_vs_busy", req_ready, !busy);
      if (done || (err && !mon_err_prev)) begin
        if (sb.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("resp_done", done, e.done);
          check("resp_err", err, e.err);
          check("resp_pulses", mon_pulses, e.pulses);
          check("resp_steps_left", steps_left, 0);
        end
        mon_pulses = 0;
      end
      mon_ps_prev  = phasestep;
      mon_err_prev = err;
    end
  end

  task automatic issue(input logic [2:0] sel, input logic up, input int steps,
                       input int mode, input int abort_after, input bit hold_valid);
    int budget;
    @(negedge clk);
    req_valid = 1'b1;
    req_cnt   = sel;
    req_up    = up;
    req_steps = steps[STEPW-1:0];
    budget = 0;
    while (!req_ready && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) check("accept_timeout", 0, 1);
    else sb.push_back(model(sel, up, steps, mode, abort_after));
    @(posedge clk); #1;
    if (!hold_valid) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || !req_ready) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0 || !req_ready) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},      req_ready,  1);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_err"},        err,        0);
    check({tag, "_steps_left"}, steps_left, 0);
    check({tag, "_select"},     pcs,        0);
    check({tag, "_updown"},     updown,     0);
    check({tag, "_phasestep"},  phasestep,  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int budget;
    rst_n = 1'b0; req_valid = 1'b0; req_cnt = '0; req_up = 1'b0; req_steps = '0; locked = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: C1, retard, 3 steps
    issue(CNT_C1, 1'b0, 3, M_NORMAL, 0, 1'b0);
    wait_idle();

    // 2: zero steps -> immediate done, no phasestep
    issue(CNT_M, 1'b1, 0, M_NORMAL, 0, 1'b0);
    check("zero_step_done_next_cycle", done, 1);
    wait_idle();

    // 3: phasedone never falls -> timeout measured from WAIT_LO entry
    pll_stuck = 1'b1;
    issue(CNT_C0, 1'b1, 2, M_STUCK, 0, 1'b0);
    budget = 0;
    while (!phasestep && budget < 20) begin @(negedge clk); budget++; end
    while (phasestep && budget < 40) begin @(negedge clk); budget++; end
    t0 = cyc;
    budget = 0;
    while (!err && budget < 400) begin @(negedge clk); budget++; end
    check("timeout_cycles", cyc - t0, TIMEOUT);
    check("timeout_phasestep", phasestep, 0);
    check("timeout_ready", req_ready, 1);
    pll_stuck = 1'b0;
    repeat (10) @(negedge clk);
    issue(CNT_C0, 1'b1, 1, M_NORMAL, 0, 1'b0);
    check("err_cleared_on_accept", err, 0);
    wait_idle();

    // 4: lock lost during step 2 of 5
    issue(CNT_C2, 1'b1, 5, M_UNLOCK, 2, 1'b0);
    budget = 0;
    while (mon_pulses < 2 && budget < 200) begin @(negedge clk); budget++; end
    while (phasestep && budget < 220) begin @(negedge clk); budget++; end
    locked = 1'b0;
    t0 = cyc;
    budget = 0;
    while (!err && budget < 10) begin @(negedge clk); budget++; end
    check("unlock_abort_within_3", (err && (cyc - t0) <= 3) ? 1 : 0, 1);
    check("unlock_steps_left", steps_left, 0);
    locked = 1'b1;
    repeat (12) @(negedge clk);
    wait_idle();

    // 5: valid held high through a 3-step run
    issue(CNT_C3, 1'b0, 3, M_NORMAL, 0, 1'b1);
    req_cnt = CNT_C4; req_up = 1'b1; req_steps = 6'd2;
    budget = 0;
    while (!done && budget < 200) begin @(negedge clk); budget++; end
    check("held_valid_ready_at_done", req_ready, 1);
    check("held_valid_still_high", req_valid, 1);
    sb.push_back(model(CNT_C4, 1'b1, 2, M_NORMAL, 0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("held_valid_second_accept", busy, 1);
    check("held_valid_second_steps", steps_left, 2);
    wait_idle();

    // 6: asynchronous reset in WAIT_HI
    issue(CNT_C1, 1'b1, 3, M_NORMAL, 0, 1'b0);
    budget = 0;
    while (phasedone && budget < 50) begin @(negedge clk); budget++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", req_ready, 1);
    repeat (12) @(negedge clk);

    // boundary: maximum step count
    issue(CNT_ALL, 1'b0, (1 << STEPW) - 1, M_NORMAL, 0, 1'b0);
    wait_idle();

    // random back-to-back requests
    for (int i = 0; i < 14; i++) begin
      issue(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
            M_NORMAL, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
